// File: rtl/vae_bram_pkg.sv
// Shared constants, state encoding and port-A write bundle for the
// forward_vae_bram host controller.
package vae_bram_pkg;

  localparam int DW           = 16;    // Q6.10 data word
  localparam int BW           = 64;    // packed BRAM row
  localparam int AW           = 4;     // BRAM address width
  localparam int N_ROWS       = 9;     // rows per BRAM / xout entries
  localparam int DONE_TIMEOUT = 1023;  // cycles allowed in WAIT_DONE

  localparam int FPR            = BW / DW;                       // fields per row
  localparam int WORDS_PER_BRAM = FPR * N_ROWS;                  // 36
  localparam int TOTAL_WORDS_W  = 3 * WORDS_PER_BRAM + N_ROWS;   // 117, weights + xin
  localparam int TOTAL_WORDS_X  = N_ROWS;                        // 9, xin only
  localparam int TO_W           = $clog2(DONE_TIMEOUT + 1);

  localparam logic [DW-1:0] Q_ONE    = 16'h0400;
  localparam logic [7:0]    WE_ALL   = 8'hff;
  localparam logic [AW-1:0] LAST_ROW = AW'(N_ROWS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_WM,
    S_LD_WV,
    S_LD_W3,
    S_LD_XIN,
    S_START,
    S_WAIT_DONE,
    S_RD_REQ,
    S_RD_CAP,
    S_RD_OUT,
    S_ERR
  } state_t;

  // One BRAM port-A write, registered as a unit.
  typedef struct packed {
    logic          ena;
    logic [AW-1:0] addr;
    logic [BW-1:0] din;
    logic [7:0]    we;
  } wr_port_t;

endpackage

// File: rtl/vae_bram_host_ctrl_row_packer.sv
// 16->64 shift packer: the first word of a row lands in the top field,
// row_full_o flags the word that completes a row.
module vae_row_packer
  import vae_bram_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          row_full_o,
  output logic [BW-1:0] row_data_o
);

  localparam int FW = $clog2(FPR);
  localparam logic [FW-1:0] FIELD_LAST = FW'(FPR - 1);

  // Only the first FPR-1 fields need storage; the last one arrives on data_i.
  logic [BW-DW-1:0] shift_q;
  logic [FW-1:0]    field_q;

  assign row_full_o = valid_i && (field_q == FIELD_LAST);
  assign row_data_o = {shift_q, data_i};

  // Shift accepted words in and track the field position within the row.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      shift_q <= '0;
      field_q <= '0;
    end else if (valid_i) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      shift_q <= {shift_q[BW-2*DW-1:0], data_i};
      field_q <= (field_q == FIELD_LAST) ? '0 : field_q + 1'b1;
    end
  end

endmodule

// File: rtl/vae_bram_host_ctrl.sv
// Host-side sequencer for forward_vae_bram: loads the weight and xin BRAMs
// from a word stream, pulses start, waits for done and streams xout back.
module vae_bram_host_ctrl
  import vae_bram_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          go_i,
  input  logic          load_w_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_data_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic          m_last_o,
  output logic          busy_o,
  output logic          err_o,
  output logic          wb2_m_ena_o,
  output logic [AW-1:0] wb2_m_addra_o,
  output logic [BW-1:0] wb2_m_dina_o,
  output logic [7:0]    wb2_m_wea_o,
  output logic          wb2_v_ena_o,
  output logic [AW-1:0] wb2_v_addra_o,
  output logic [BW-1:0] wb2_v_dina_o,
  output logic [7:0]    wb2_v_wea_o,
  output logic          wb3_ena_o,
  output logic [AW-1:0] wb3_addra_o,
  output logic [BW-1:0] wb3_dina_o,
  output logic [7:0]    wb3_wea_o,
  output logic          xin_ena_o,
  output logic [AW-1:0] xin_addra_o,
  output logic [DW-1:0] xin_dina_o,
  output logic [7:0]    xin_wea_o,
  output logic          start_o,
  input  logic          done_i,
  output logic          xout_enb_o,
  output logic [AW-1:0] xout_addrb_o,
  input  logic [DW-1:0] xout_doutb_i
);

  state_t          state_q;
  logic [AW-1:0]   row_q;      // row within the 64-bit BRAM being loaded
  logic [AW-1:0]   xidx_q;     // xin write address
  logic [AW-1:0]   rd_k_q;     // xout readback index
  logic [TO_W-1:0] tmo_q;      // cycles spent in WAIT_DONE
  logic            done_q;     // previous done level, for edge detection
  wr_port_t        wp_q [0:2]; // wb2_m, wb2_v, wb3
  logic            xin_ena_q;
  logic [AW-1:0]   xin_addr_q;
  logic [DW-1:0]   xin_din_q;
  logic [7:0]      xin_we_q;
  logic            start_q;
  logic            m_valid_q;
  logic [DW-1:0]   m_data_q;
  logic            m_last_q;
  logic            err_q;

  logic            load_w_st;
  logic            accept;
  logic            go_acc;
  logic            row_full;
  logic [BW-1:0]   row_data;
  logic [1:0]      bsel;
  state_t          nxt_ld;

  assign load_w_st = state_q inside {S_LD_WM, S_LD_WV, S_LD_W3};
  assign s_ready_o = load_w_st || (state_q == S_LD_XIN);
  assign accept    = s_valid_i && s_ready_o;
  assign go_acc    = go_i && (state_q inside {S_IDLE, S_ERR});
  assign busy_o    = !(state_q inside {S_IDLE, S_ERR});

  // The BRAM read is issued straight from RD_REQ so data is ready in RD_CAP.
  assign xout_enb_o   = (state_q == S_RD_REQ);
  assign xout_addrb_o = rd_k_q;

  vae_row_packer u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (go_acc),
    .valid_i    (accept && load_w_st),
    .data_i     (s_data_i),
    .row_full_o (row_full),
    .row_data_o (row_data)
  );

  // Select the weight BRAM being loaded and the load state that follows it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    bsel   = 2'd2;
    nxt_ld = S_LD_XIN;
    case (state_q)
      S_LD_WM: begin bsel = 2'd0; nxt_ld = S_LD_WV; end
      S_LD_WV: begin bsel = 2'd1; nxt_ld = S_LD_W3; end
      default: ;
    endcase
  end

  // Sequencer FSM with all strobes and stream outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      xidx_q     <= '0;
      rd_k_q     <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      for (int b = 0; b < 3; b++) wp_q[b] <= '0;
      xin_ena_q  <= 1'b0;
      xin_addr_q <= '0;
      xin_din_q  <= '0;
      xin_we_q   <= '0;
      start_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Write strobes and start are single-cycle unless re-asserted below.
      for (int b = 0; b < 3; b++) begin
        wp_q[b].ena <= 1'b0;
        wp_q[b].we  <= '0;
      end
      xin_ena_q <= 1'b0;
      xin_we_q  <= '0;
      start_q   <= 1'b0;
      done_q    <= done_i;

      case (state_q)
        S_IDLE, S_ERR: begin
          if (go_i) begin
            err_q   <= 1'b0;
            row_q   <= '0;
            xidx_q  <= '0;
            rd_k_q  <= '0;
            state_q <= load_w_i ? S_LD_WM : S_LD_XIN;
          end
        end
        S_LD_WM, S_LD_WV, S_LD_W3: begin
          if (row_full) begin
            wp_q[bsel].ena  <= 1'b1;
            wp_q[bsel].we   <= WE_ALL;
            wp_q[bsel].addr <= row_q;
            wp_q[bsel].din  <= row_data;
            if (row_q == LAST_ROW) begin
              row_q   <= '0;
              state_q <= nxt_ld;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        S_LD_XIN: begin
          if (accept) begin
            xin_ena_q  <= 1'b1;
            xin_we_q   <= WE_ALL;
            xin_addr_q <= xidx_q;
            xin_din_q  <= s_data_i;
            if (xidx_q == LAST_ROW) begin
              xidx_q  <= '0;
              state_q <= S_START;
            end else begin
              xidx_q <= xidx_q + 1'b1;
            end
          end
        end
        S_START: begin
          start_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done_i && !done_q) begin
            state_q <= S_RD_REQ;
          end else if (tmo_q == TO_W'(DONE_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RD_REQ: state_q <= S_RD_CAP;
        S_RD_CAP: begin
          m_data_q  <= xout_doutb_i;
          m_valid_q <= 1'b1;
          m_last_q  <= (rd_k_q == LAST_ROW);
          state_q   <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (rd_k_q == LAST_ROW) begin
              rd_k_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              rd_k_q  <= rd_k_q + 1'b1;
              state_q <= S_RD_REQ;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb2_m_ena_o   = wp_q[0].ena;
  assign wb2_m_addra_o = wp_q[0].addr;
  assign wb2_m_dina_o  = wp_q[0].din;
  assign wb2_m_wea_o   = wp_q[0].we;
  assign wb2_v_ena_o   = wp_q[1].ena;
  assign wb2_v_addra_o = wp_q[1].addr;
  assign wb2_v_dina_o  = wp_q[1].din;
  assign wb2_v_wea_o   = wp_q[1].we;
  assign wb3_ena_o     = wp_q[2].ena;
  assign wb3_addra_o   = wp_q[2].addr;
  assign wb3_dina_o    = wp_q[2].din;
  assign wb3_wea_o     = wp_q[2].we;
  assign xin_ena_o     = xin_ena_q;
  assign xin_addra_o   = xin_addr_q;
  assign xin_dina_o    = xin_din_q;
  assign xin_wea_o     = xin_we_q;
  assign start_o       = start_q;
  assign m_valid_o     = m_valid_q;
  assign m_data_o      = m_data_q;
  assign m_last_o      = m_last_q;
  assign err_o         = err_q;

endmodule
